reflet_int_ctrl: RTL and testbench

REFLET_INT_CTRL -- requirements
Module: reflet_int_ctrl

---
 rtl/reflet_int_ctrl.sv | 177 +++++++++++++++++
 tb/tb_reflet_int_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_int_ctrl.sv
// -----------------------------------------------------------------------------
// reflet_int_ctrl
//   Four-source interrupt controller sitting on a simple CPU register bus.
//   Raw sources are synchronized, latched into PENDING (edge or level mode per
//   source), gated by MASK and arbitrated with fixed priority (source 0 wins).
//   The winner is presented one-hot on ext_int until it is cleared or masked.
//   A single idle cycle (GAP) then separates it from the next arbitration.
//
//   Register map (relative to base_addr):
//     +0 MASK    rw   bits 3:0
//     +1 MODE    rw   bits 3:0, 1 = edge, 0 = level
//     +2 PENDING r    bits 3:0, write-1-to-clear
//     +3 STATUS  r    bits 3:0 = ext_int, bit 7 = an interrupt is presented
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-low reset
//   irq_in    in   [3:0] raw interrupt sources, asynchronous to clk
//   addr      in   [wordsize-1:0] CPU bus address
//   data_in   in   [wordsize-1:0] CPU write data
//   write_en  in   CPU write strobe
//   data_out  out  [wordsize-1:0] registered read data, 0 when not addressed
//   ext_int   out  [3:0] one-hot interrupt lines to the CPU
// -----------------------------------------------------------------------------
module reflet_int_ctrl #(
    parameter int          wordsize  = 8,
    parameter int unsigned base_addr = 'hF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          irq_in,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic [3:0]          ext_int
);

    localparam logic [wordsize-1:0] base_w = wordsize'(base_addr);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Two-flop synchronizer plus one history stage for edge detection.
    logic [3:0] sync1_q;
    logic [3:0] s_q;
    logic [3:0] s_prev_q;

    logic [3:0]          mask_q, mask_d;
    logic [3:0]          mode_q, mode_d;
    logic [3:0]          pend_q, pend_d;
    state_t              state_q, state_d;
    logic [1:0]          cur_q, cur_d;
    logic [wordsize-1:0] data_out_q, data_out_d;

    logic       hit;
    logic [1:0] reg_sel;
    logic [3:0] set_v;
    logic [3:0] w1c;
    logic [3:0] req;

    // Only the low nibble of write data is architected.
    logic unused_data_bits;
    assign unused_data_bits = ^data_in[wordsize-1:4];

    assign hit     = (addr[wordsize-1:2] == base_w[wordsize-1:2]);
    assign reg_sel = addr[1:0];

    // -------------------------------------------------------------------------
    // Register file and PENDING update
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        mask_d = mask_q;
        mode_d = mode_q;
        w1c    = '0;

        if (write_en && hit) begin
            case (reg_sel)
                2'd0:    mask_d = data_in[3:0];
                2'd1:    mode_d = data_in[3:0];
                2'd2:    w1c    = data_in[3:0];
                default: ;  // STATUS is read-only
            endcase
        end

        // Edge sources set on a synchronized 0->1, level sources while high.
        set_v  = (mode_q & s_q & ~s_prev_q) | (~mode_q & s_q);
        // Set is OR-ed after the clear so a same-cycle set always survives.
        pend_d = (pend_q & ~w1c) | set_v;
    end

    // -------------------------------------------------------------------------
    // Arbitration FSM
    // -------------------------------------------------------------------------
    assign req = pend_q & mask_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    // Scan downward so the lowest requesting index is kept.
                    for (int i = 3; i >= 0; i--) begin
                        if (req[i]) cur_d = 2'(i);
                    end
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // No preemption: only loss of the current source ends service.
                if (!pend_q[cur_q] || !mask_q[cur_q]) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ext_int = '0;
        if (state_q == ACTIVE) ext_int[cur_q] = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Read mux; a miss returns zero so several slaves can be OR-ed together.
    // -------------------------------------------------------------------------
    always_comb begin
        data_out_d = '0;
        if (hit) begin
            case (reg_sel)
                2'd0: data_out_d[3:0] = mask_q;
                2'd1: data_out_d[3:0] = mode_q;
                2'd2: data_out_d[3:0] = pend_q;
                default: begin
                    data_out_d[3:0] = ext_int;
                    data_out_d[7]   = (state_q == ACTIVE);
                end
            endcase
        end
    end

    assign data_out = data_out_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            s_q        <= '0;
            s_prev_q   <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            state_q    <= IDLE;
            cur_q      <= '0;
            data_out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values.
            sync1_q    <= irq_in;
            s_q        <= sync1_q;
            s_prev_q   <= s_q;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_reflet_int_ctrl.sv
module tb_reflet_int_ctrl;

    localparam logic [7:0] A_MASK = 8'hF0;
    localparam logic [7:0] A_MODE = 8'hF1;
    localparam logic [7:0] A_PEND = 8'hF2;
    localparam logic [7:0] A_STAT = 8'hF3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       write_en;
    logic [7:0] data_out;
    logic [3:0] ext_int;

    int n_cmp = 0;
    int n_bad = 0;

    reflet_int_ctrl #(.wordsize(8), .base_addr('hF0)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .addr     (addr),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out),
        .ext_int  (ext_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       we;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; write_en = 1'b1;
        tick();
        write_en = 1'b0; addr = 8'h00; data_in = 8'h00;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        tick();
        check(name, data_out, exp);
        addr = 8'h00;
    endtask

    // Bounded wait for an interrupt line, then compare it.
    task automatic wait_int(input string name, input logic [3:0] exp);
        for (int i = 0; i < 10; i++) begin
            if (ext_int != 4'd0) break;
            tick();
        end
        check(name, {4'd0, ext_int}, {4'd0, exp});
    endtask

    task automatic pulse(input logic [3:0] bits);
        irq_in = bits;
        tick();
        irq_in = 4'd0;
    endtask

    initial begin
        vecs[0]  = '{A_MASK, 8'h00, 1'b0, 8'h00, "rst_mask"};
        vecs[1]  = '{A_MODE, 8'h00, 1'b0, 8'h00, "rst_mode"};
        vecs[2]  = '{A_PEND, 8'h00, 1'b0, 8'h00, "rst_pend"};
        vecs[3]  = '{A_STAT, 8'h00, 1'b0, 8'h00, "rst_status"};
        vecs[4]  = '{A_MASK, 8'hFF, 1'b1, 8'h00, "wr_mask"};
        vecs[5]  = '{A_MASK, 8'h00, 1'b0, 8'h0F, "mask_upper_zero"};
        vecs[6]  = '{A_MODE, 8'hA5, 1'b1, 8'h00, "wr_mode"};
        vecs[7]  = '{A_MODE, 8'h00, 1'b0, 8'h05, "mode_readback"};
        vecs[8]  = '{A_STAT, 8'hFF, 1'b1, 8'h00, "wr_status"};
        vecs[9]  = '{A_STAT, 8'h00, 1'b0, 8'h00, "status_ignored"};
        vecs[10] = '{8'hEF,  8'h00, 1'b0, 8'h00, "read_base_m1"};
        vecs[11] = '{8'hF4,  8'h00, 1'b0, 8'h00, "read_base_p4"};
        vecs[12] = '{A_MASK, 8'h00, 1'b1, 8'h00, "clr_mask"};
        vecs[13] = '{A_MODE, 8'h00, 1'b1, 8'h00, "clr_mode"};
        vecs[14] = '{A_MASK, 8'h00, 1'b0, 8'h00, "mask_cleared"};

        reset = 1'b0; irq_in = 4'hF; addr = A_STAT; data_in = 8'h00; write_en = 1'b0;

        // Reset held with all sources high.
        repeat (4) tick();
        check("rst_ext_int", {4'd0, ext_int}, 8'h00);
        check("rst_data_out", data_out, 8'h00);
        irq_in = 4'h0;
        repeat (3) tick();
        reset = 1'b1;
        addr  = 8'h00;

        // Register access vectors.
        foreach (vecs[i]) begin
            addr = vecs[i].a; data_in = vecs[i].d; write_en = vecs[i].we;
            tick();
            write_en = 1'b0;
            if (!vecs[i].we) check(vecs[i].name, data_out, vecs[i].exp);
        end
        addr = 8'h00;

        // Edge source 0: PENDING after 3 edges, ext_int after 4.
        wr(A_MASK, 8'h01);
        wr(A_MODE, 8'h01);
        addr = A_PEND;
        pulse(4'h1);                                    // edge 1
        tick();                                         // edge 2
        tick();                                         // edge 3
        check("edge_pend_e3_rd", data_out, 8'h00);
        check("edge_ext_e3", {4'd0, ext_int}, 8'h00);
        tick();                                         // edge 4
        check("edge_pend_e4_rd", data_out, 8'h01);
        check("edge_ext_e4", {4'd0, ext_int}, 8'h01);
        addr = 8'h00;
        rd_check("edge_status_active", A_STAT, 8'h81);
        wr(A_PEND, 8'h01);
        tick();
        check("edge_ext_after_w1c", {4'd0, ext_int}, 8'h00);
        rd_check("edge_status_idle", A_STAT, 8'h00);
        rd_check("edge_pend_cleared", A_PEND, 8'h00);

        // Priority and GAP between services.
        wr(A_MASK, 8'h0F);
        wr(A_MODE, 8'h0F);
        pulse(4'hA);
        wait_int("prio_first", 4'b0010);
        wr(A_PEND, 8'h02);
        tick();
        check("prio_gap", {4'd0, ext_int}, 8'h00);
        tick();
        check("prio_idle", {4'd0, ext_int}, 8'h00);
        tick();
        check("prio_second", {4'd0, ext_int}, 8'h08);
        pulse(4'h1);
        repeat (5) tick();
        check("no_preempt", {4'd0, ext_int}, 8'h08);
        rd_check("pend_both", A_PEND, 8'h09);
        wr(A_PEND, 8'h0F);
        repeat (4) tick();
        check("prio_drained", {4'd0, ext_int}, 8'h00);

        // Level mode: W1C ignored while the source is high.
        wr(A_MODE, 8'h00);
        wr(A_MASK, 8'h04);
        irq_in = 4'h4;
        wait_int("level_first", 4'b0100);
        wr(A_PEND, 8'h04);
        repeat (2) tick();
        rd_check("level_pend_stuck", A_PEND, 8'h04);
        check("level_ext_stuck", {4'd0, ext_int}, 8'h04);
        irq_in = 4'h0;
        repeat (3) tick();
        wr(A_PEND, 8'h04);
        repeat (2) tick();
        check("level_ext_off", {4'd0, ext_int}, 8'h00);
        rd_check("level_pend_off", A_PEND, 8'h00);

        // Masking: PENDING latches with MASK=0, MASK controls presentation.
        wr(A_MASK, 8'h00);
        wr(A_MODE, 8'h02);
        pulse(4'h2);
        repeat (4) tick();
        check("masked_ext", {4'd0, ext_int}, 8'h00);
        rd_check("masked_pend", A_PEND, 8'h02);
        wr(A_MASK, 8'h02);
        check("unmask_idle", {4'd0, ext_int}, 8'h00);
        tick();
        check("unmask_active", {4'd0, ext_int}, 8'h02);
        wr(A_MASK, 8'h00);
        tick();
        check("remask_gap", {4'd0, ext_int}, 8'h00);
        rd_check("remask_status", A_STAT, 8'h00);
        rd_check("remask_pend_kept", A_PEND, 8'h02);

        // Set/clear collision on an edge source: set wins.
        wr(A_PEND, 8'h0F);
        wr(A_MODE, 8'h04);
        pulse(4'h4);                                    // edge 1
        tick();                                         // edge 2
        wr(A_PEND, 8'h04);                              // edge 3 sets and clears
        rd_check("collision_set_wins", A_PEND, 8'h04);
        wr(A_PEND, 8'h04);
        rd_check("collision_then_clear", A_PEND, 8'h00);

        // Reset while ACTIVE.
        wr(A_MODE, 8'h01);
        wr(A_MASK, 8'h01);
        pulse(4'h1);
        wait_int("pre_reset_active", 4'b0001);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_ext", {4'd0, ext_int}, 8'h00);
        check("async_reset_dout", data_out, 8'h00);
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();
        check("post_reset_ext", {4'd0, ext_int}, 8'h00);
        rd_check("post_reset_mask", A_MASK, 8'h00);
        rd_check("post_reset_pend", A_PEND, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
